// File: rtl/i2s_pkg.sv
// Shared I2S constants and receive FSM state type.
// Default widths are common to i2s_rx and i2s_out.
package i2s_pkg;

   typedef enum logic [1:0] {
      RX_SYNC,
      RX_LEFT,
      RX_RIGHT
   } i2s_rx_state_t;

   localparam int I2S_SYNC_STAGES     = 2;
   localparam int I2S_DATA_W          = 24;
   localparam int I2S_SLOT_W          = 32;
   localparam int I2S_PEAK_DECAY_LOG2 = 20;

endpackage

// File: rtl/i2s_rx_pin_sync.sv
// Synchronises SCLK/LRCLK/DIN into Clk and flags SCLK rising edges.
// Outputs are registered so rise, lr and din share one cycle alignment.
module i2s_pin_sync
   import i2s_pkg::*;
(
   input  logic Clk,
   input  logic Reset,
   input  logic SCLK,
   input  logic LRCLK,
   input  logic DIN,
   output logic sclk_rise,
   output logic lr_s,
   output logic din_s
);

   localparam int N = I2S_SYNC_STAGES;

   logic [N-1:0] sclk_sync_q, sclk_sync_d;
   logic [N-1:0] lr_sync_q, lr_sync_d;
   logic [N-1:0] din_sync_q, din_sync_d;
   logic         sclk_dly_q, sclk_dly_d;
   logic         rise_q, rise_d;
   logic         lr_q, lr_d;
   logic         din_q, din_d;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[N-2:0], SCLK};
      lr_sync_d   = {lr_sync_q[N-2:0], LRCLK};
      din_sync_d  = {din_sync_q[N-2:0], DIN};
      sclk_dly_d  = sclk_sync_q[N-1];
      rise_d      = sclk_sync_q[N-1] & ~sclk_dly_q;
      lr_d        = lr_sync_q[N-1];
      din_d       = din_sync_q[N-1];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sclk_sync_q <= '0;
         lr_sync_q   <= '0;
         din_sync_q  <= '0;
         sclk_dly_q  <= 1'b0;
         rise_q      <= 1'b0;
         lr_q        <= 1'b0;
         din_q       <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         lr_sync_q   <= lr_sync_d;
         din_sync_q  <= din_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         rise_q      <= rise_d;
         lr_q        <= lr_d;
         din_q       <= din_d;
      end
   end

   assign sclk_rise = rise_q;
   assign lr_s      = lr_q;
   assign din_s     = din_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled pins, MSB-first one-bit-delayed deserialiser.
// Define I2S_RX_PEAK_EN to build the decaying |sample| peak detector.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W,
   parameter int SLOT_W = I2S_SLOT_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              SCLK,
   input  logic              LRCLK,
   input  logic              DIN,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              pair_valid,
   output logic              frame_err,
   output logic [DATA_W-2:0] peak_level
);

   localparam int CNT_W = $clog2(SLOT_W + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);
   localparam logic [CNT_W-1:0] CNT_ERR  = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

   logic sclk_rise, lr, din;

   i2s_pin_sync u_pin_sync (
      .Clk       (Clk),
      .Reset     (Reset),
      .SCLK      (SCLK),
      .LRCLK     (LRCLK),
      .DIN       (DIN),
      .sclk_rise (sclk_rise),
      .lr_s      (lr),
      .din_s     (din)
   );

   i2s_rx_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] left_q, left_d;
   logic [DATA_W-1:0] right_q, right_d;
   logic              lr_prev_q, lr_prev_d;
   logic              pend_q, pend_d;
   logic              pv_q, pv_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] sh_in;
   logic [CNT_W-1:0]  nbits;
   logic [DATA_W-1:0] word;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      hold_d    = hold_q;
      left_d    = left_q;
      right_d   = right_q;
      lr_prev_d = lr_prev_q;
      err_d     = err_q;
      pend_d    = 1'b0;
      pv_d      = pend_q;
      // Bits beyond DATA_W are dropped; short words are left-justified.
      if (cnt_q < CNT_DATA) begin
         sh_in = {sh_q[DATA_W-2:0], din};
         nbits = cnt_q + 1'b1;
      end else begin
         sh_in = sh_q;
         nbits = CNT_DATA;
      end
      word = sh_in << (CNT_DATA - nbits);
      if (sclk_rise) begin
         lr_prev_d = lr;
         case (state_q)
            RX_SYNC: begin
               if (lr_prev_q && !lr) begin
                  state_d = RX_LEFT;
                  cnt_d   = '0;
                  sh_d    = '0;
               end
            end
            RX_LEFT, RX_RIGHT: begin
               if (lr == lr_prev_q) begin
                  sh_d = sh_in;
                  if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
                  if (cnt_q >= CNT_ERR) err_d = 1'b1;
               end else begin
                  cnt_d = '0;
                  sh_d  = '0;
                  if (state_q == RX_LEFT) begin
                     hold_d  = word;
                     state_d = RX_RIGHT;
                  end else begin
                     left_d  = hold_q;
                     right_d = word;
                     pend_d  = 1'b1;
                     state_d = RX_LEFT;
                  end
               end
            end
            default: state_d = RX_SYNC;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= RX_SYNC;
         cnt_q     <= '0;
         sh_q      <= '0;
         hold_q    <= '0;
         left_q    <= '0;
         right_q   <= '0;
         lr_prev_q <= 1'b0;
         pend_q    <= 1'b0;
         pv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         hold_q    <= hold_d;
         left_q    <= left_d;
         right_q   <= right_d;
         lr_prev_q <= lr_prev_d;
         pend_q    <= pend_d;
         pv_q      <= pv_d;
         err_q     <= err_d;
      end
   end

   assign left_data  = left_q;
   assign right_data = right_q;
   assign pair_valid = pv_q;
   assign frame_err  = err_q;

`ifdef I2S_RX_PEAK_EN
   logic [DATA_W-2:0]              peak_q, peak_d;
   logic [DATA_W-2:0]              abs_l, abs_r;
   logic [I2S_PEAK_DECAY_LOG2-1:0] tick_q, tick_d;

   function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] neg;
      neg = -x;
      if (!x[DATA_W-1]) return x[DATA_W-2:0];
      if (x[DATA_W-2:0] == '0) return '1;
      return neg[DATA_W-2:0];
   endfunction

   always_comb begin
      tick_d = tick_q + 1'b1;
      peak_d = peak_q;
      abs_l  = abs_sat(left_q);
      abs_r  = abs_sat(right_q);
      if (pv_q) begin
         if (abs_l > peak_d) peak_d = abs_l;
         if (abs_r > peak_d) peak_d = abs_r;
      end else if (tick_q == '1) begin
         peak_d = peak_q >> 1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         peak_q <= '0;
         tick_q <= '0;
      end else begin
         peak_q <= peak_d;
         tick_q <= tick_d;
      end
   end

   assign peak_level = peak_q;
`else
   assign peak_level = '0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: codec model drives I2S frames,
// each task checks its own scenario against hand-computed values.
module tb_i2s_rx;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        SCLK = 1'b0;
   logic        LRCLK = 1'b0;
   logic        DIN = 1'b0;
   logic [23:0] left_data, right_data;
   logic        pair_valid, frame_err;
   logic [22:0] peak_level;

   int checks = 0;
   int errors = 0;
   int pv_cnt = 0;
   int dbl = 0;
   logic pv_prev = 1'b0;
   logic [23:0] cap_l = '0, cap_r = '0;

   i2s_rx dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .SCLK       (SCLK),
      .LRCLK      (LRCLK),
      .DIN        (DIN),
      .left_data  (left_data),
      .right_data (right_data),
      .pair_valid (pair_valid),
      .frame_err  (frame_err),
      .peak_level (peak_level)
   );

   always #10 Clk = ~Clk;

   always @(negedge Clk) begin
      if (pair_valid) begin
         pv_cnt++;
         cap_l = left_data;
         cap_r = right_data;
         if (pv_prev) dbl++;
      end
      pv_prev = pair_valid;
   end

   task automatic send_bit(input logic lr, input logic d);
      SCLK = 1'b0;
      LRCLK = lr;
      DIN = d;
      #163;
      SCLK = 1'b1;
      #163;
   endtask

   task automatic send_slot(input logic [63:0] w, input int n, input logic lr);
      for (int i = n - 1; i >= 1; i--) send_bit(lr, w[i]);
      send_bit(~lr, w[0]);
   endtask

   task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
      send_slot(l, n, 1'b0);
      send_slot(r, n, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      pv_cnt = 0;
   endtask

   task automatic test_reset();
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      checks++;
      if (left_data !== 24'h0) begin
         errors++;
         $display("FAIL rst_left got %h want 000000", left_data);
      end
      checks++;
      if (right_data !== 24'h0) begin
         errors++;
         $display("FAIL rst_right got %h want 000000", right_data);
      end
      checks++;
      if (pair_valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags got pv=%b err=%b want 0 0", pair_valid, frame_err);
      end
      checks++;
      if (peak_level !== 23'h0) begin
         errors++;
         $display("FAIL rst_peak got %h want 000000", peak_level);
      end
   endtask

   task automatic test_basic();
      do_reset();
      for (int f = 0; f < 3; f++) send_frame(64'h12345600, 64'hABCDEF00, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (pv_cnt !== 2) begin
         errors++;
         $display("FAIL basic_count got %0d want 2", pv_cnt);
      end
      checks++;
      if (cap_l !== 24'h123456) begin
         errors++;
         $display("FAIL basic_left got %h want 123456", cap_l);
      end
      checks++;
      if (cap_r !== 24'hABCDEF) begin
         errors++;
         $display("FAIL basic_right got %h want abcdef", cap_r);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_err got %b want 0", frame_err);
      end
`ifndef I2S_RX_PEAK_EN
      checks++;
      if (peak_level !== 23'h0) begin
         errors++;
         $display("FAIL peak_off got %h want 000000", peak_level);
      end
`endif
   endtask

   task automatic test_mid_slot();
      do_reset();
      for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
      checks++;
      if (pv_cnt !== 0) begin
         errors++;
         $display("FAIL mid_partial got %0d want 0", pv_cnt);
      end
      send_bit(1'b0, 1'b1);
      repeat (10) @(negedge Clk);
      checks++;
      if (pv_cnt !== 0) begin
         errors++;
         $display("FAIL mid_edge got %0d want 0", pv_cnt);
      end
      send_frame(64'h0F0F0F00, 64'h55AA5500, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (pv_cnt !== 1) begin
         errors++;
         $display("FAIL mid_count got %0d want 1", pv_cnt);
      end
      checks++;
      if (cap_l !== 24'h0F0F0F || cap_r !== 24'h55AA55) begin
         errors++;
         $display("FAIL mid_pair got %h %h want 0f0f0f 55aa55", cap_l, cap_r);
      end
   endtask

   task automatic test_short_slot();
      do_reset();
      for (int f = 0; f < 3; f++) send_frame(64'h8001, 64'h7FFE, 16);
      repeat (20) @(negedge Clk);
      checks++;
      if (pv_cnt !== 2) begin
         errors++;
         $display("FAIL short_count got %0d want 2", pv_cnt);
      end
      checks++;
      if (left_data !== 24'h800100) begin
         errors++;
         $display("FAIL short_left got %h want 800100", left_data);
      end
      checks++;
      if (right_data !== 24'h7FFE00) begin
         errors++;
         $display("FAIL short_right got %h want 7ffe00", right_data);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL short_err got %b want 0", frame_err);
      end
   endtask

   task automatic test_long_slot();
      do_reset();
      for (int f = 0; f < 3; f++)
         send_frame(64'h654321_0000, 64'h00FFEE_BEEF, 40);
      repeat (20) @(negedge Clk);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL long_err got %b want 1", frame_err);
      end
      checks++;
      if (left_data !== 24'h654321 || right_data !== 24'h00FFEE) begin
         errors++;
         $display("FAIL long_pair got %h %h want 654321 00ffee", left_data, right_data);
      end
      send_frame(64'h11223300, 64'h44556600, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL long_sticky got %b want 1", frame_err);
      end
      checks++;
      if (left_data !== 24'h112233 || right_data !== 24'h445566) begin
         errors++;
         $display("FAIL long_after got %h %h want 112233 445566", left_data, right_data);
      end
      do_reset();
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL long_clear got %b want 0", frame_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] l;
      l = 64'h3C3C3C00;
      do_reset();
      send_frame(64'hA5A5A500, 64'h5A5A5A00, 32);
      send_frame(64'hA5A5A500, 64'h5A5A5A00, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (left_data !== 24'hA5A5A5) begin
         errors++;
         $display("FAIL rmid_pre got %h want a5a5a5", left_data);
      end
      for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
      do_reset();
      checks++;
      if (left_data !== 24'h0 || right_data !== 24'h0 || pair_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_clear got %h %h %b want 0 0 0", left_data, right_data, pair_valid);
      end
      for (int i = 0; i < 21; i++) send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_slot(64'hFFFFFFFF, 32, 1'b1);
      send_frame(l, 64'hC3C3C300, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (pv_cnt !== 1) begin
         errors++;
         $display("FAIL rmid_count got %0d want 1", pv_cnt);
      end
      checks++;
      if (cap_l !== 24'h3C3C3C || cap_r !== 24'hC3C3C3) begin
         errors++;
         $display("FAIL rmid_pair got %h %h want 3c3c3c c3c3c3", cap_l, cap_r);
      end
   endtask

   task automatic test_latency_stop();
      logic [63:0] r;
      int lat;
      int base;
      r = 64'h01234500;
      lat = 0;
      send_slot(64'hFEDCBA00, 32, 1'b0);
      for (int i = 31; i >= 1; i--) send_bit(1'b1, r[i]);
      SCLK = 1'b0;
      LRCLK = 1'b0;
      DIN = r[0];
      #163;
      @(negedge Clk);
      SCLK = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge Clk);
         #1;
         if (pair_valid && lat == 0) lat = i;
         if (i == 6) begin
            checks++;
            if (pair_valid !== 1'b0) begin
               errors++;
               $display("FAIL lat_pulse got %b want 0", pair_valid);
            end
         end
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL lat_cycles got %0d want 5", lat);
      end
      checks++;
      if (left_data !== 24'hFEDCBA || right_data !== 24'h012345) begin
         errors++;
         $display("FAIL lat_pair got %h %h want fedcba 012345", left_data, right_data);
      end
      base = pv_cnt;
      repeat (200) @(negedge Clk);
      checks++;
      if (pv_cnt !== base || left_data !== 24'hFEDCBA || right_data !== 24'h012345) begin
         errors++;
         $display("FAIL stop_hold got %0d %h %h want %0d fedcba 012345",
                  pv_cnt, left_data, right_data, base);
      end
      send_frame(64'h7FFFFF00, 64'h80000000, 32);
      repeat (20) @(negedge Clk);
      checks++;
      if (pv_cnt !== base + 1 || cap_l !== 24'h7FFFFF || cap_r !== 24'h800000) begin
         errors++;
         $display("FAIL resume_pair got %0d %h %h want %0d 7fffff 800000",
                  pv_cnt, cap_l, cap_r, base + 1);
      end
   endtask

`ifdef I2S_RX_PEAK_EN
   task automatic test_peak();
      do_reset();
      send_frame(64'h80000000, 64'h00001000, 32);
      send_frame(64'h80000000, 64'h00001000, 32);
      repeat (10) @(negedge Clk);
      checks++;
      if (peak_level !== 23'h7FFFFF) begin
         errors++;
         $display("FAIL peak_max got %h want 7fffff", peak_level);
      end
      repeat (1 << 20) @(posedge Clk);
      #1;
      checks++;
      if (peak_level !== 23'h3FFFFF) begin
         errors++;
         $display("FAIL peak_decay got %h want 3fffff", peak_level);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_mid_slot();
      test_short_slot();
      test_long_slot();
      test_reset_mid();
      test_latency_stop();
`ifdef I2S_RX_PEAK_EN
      test_peak();
`endif
      checks++;
      if (dbl !== 0) begin
         errors++;
         $display("FAIL pv_back_to_back got %0d want 0", dbl);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
